// File: rtl/conv_ctrl_if.sv
// Host stream and pipeline-control bundle of the convolution controller.
// The master side is the host/pipeline; the slave side is conv_ctrl.
interface conv_ctrl_if;
  logic        user_w_config_wren;
  logic [31:0] user_w_config_data;
  logic        user_w_config_open;
  logic [4:0]  user_config_addr;
  logic        user_config_addr_update;
  logic        user_w_config_full;
  logic        user_w_command_wren;
  logic [7:0]  user_w_command_data;
  logic        user_w_command_open;
  logic        user_w_command_full;
  logic        out_word_valid;
  logic        user_r_read_32_open;
  logic        user_r_read_32_eof;
  logic [11:0] cfg_width;
  logic [11:0] cfg_height;
  logic [7:0]  cfg_n_kernels;
  logic [4:0]  cfg_shift;
  logic        pipe_start;
  logic        pipe_abort;
  logic        busy;
  logic        cfg_err;

  modport master (
    output user_w_config_wren, user_w_config_data, user_w_config_open,
           user_config_addr, user_config_addr_update,
           user_w_command_wren, user_w_command_data, user_w_command_open,
           out_word_valid, user_r_read_32_open,
    input  user_w_config_full, user_w_command_full, user_r_read_32_eof,
           cfg_width, cfg_height, cfg_n_kernels, cfg_shift,
           pipe_start, pipe_abort, busy, cfg_err
  );

  modport slave (
    input  user_w_config_wren, user_w_config_data, user_w_config_open,
           user_config_addr, user_config_addr_update,
           user_w_command_wren, user_w_command_data, user_w_command_open,
           out_word_valid, user_r_read_32_open,
    output user_w_config_full, user_w_command_full, user_r_read_32_eof,
           cfg_width, cfg_height, cfg_n_kernels, cfg_shift,
           pipe_start, pipe_abort, busy, cfg_err
  );
endinterface

// File: rtl/conv_ctrl.sv
// Convolution job controller: config register file, start/abort command decode,
// job-size computation and result-word counting with end-of-frame to the host.
module conv_ctrl (
  input  logic       bus_clk,
  input  logic       bus_rst_n,
  conv_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC1 = 3'd1,
    CALC2 = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [7:0] CMD_START = 8'h01;
  localparam logic [7:0] CMD_ABORT = 8'h02;

  logic [1:0]  r_rst_sync;
  logic        w_rst_n;
  state_t      r_state;
  state_t      w_next;
  logic [11:0] r_cfg_width;
  logic [11:0] r_cfg_height;
  logic [7:0]  r_cfg_n_kernels;
  logic [4:0]  r_cfg_shift;
  logic        r_cfg_err;
  logic [23:0] r_wh;
  logic [31:0] r_total;
  logic [31:0] r_count;
  logic        r_pipe_start;
  logic        r_pipe_abort;
  logic        r_eof;
  logic        r_busy;
  logic        w_start;
  logic        w_abort;
  logic        w_last;
  logic [23:0] w_wh;
  logic [31:0] w_total;
  logic        w_unused;

  // Reset asserts immediately but releases only after two clock edges.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_start = bus.user_w_command_wren && (bus.user_w_command_data == CMD_START);
  assign w_abort = bus.user_w_command_wren && (bus.user_w_command_data == CMD_ABORT);
  assign w_last  = bus.out_word_valid && ((r_count + 32'd1) == r_total);
  assign w_wh    = {12'd0, r_cfg_width} * {12'd0, r_cfg_height};
  assign w_total = {8'd0, r_wh} * {24'd0, r_cfg_n_kernels};

  // Next-state decode; an abort outside IDLE overrides every other transition.
  always_comb begin
    w_next = r_state;
    if (w_abort && (r_state != IDLE)) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_next = w_start ? CALC1 : IDLE;
        CALC1:   w_next = CALC2;
        CALC2:   w_next = (w_total != 32'd0) ? RUN : DONE;
        RUN:     w_next = w_last ? DONE : RUN;
        DONE:    w_next = bus.user_r_read_32_open ? DONE : IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // FSM state, job arithmetic, word counter and registered control outputs.
  always_ff @(posedge bus_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state      <= IDLE;
      r_wh         <= 24'd0;
      r_total      <= 32'd0;
      r_count      <= 32'd0;
      r_pipe_start <= 1'b0;
      r_pipe_abort <= 1'b0;
      r_eof        <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_busy       <= (w_next != IDLE);
      r_eof        <= (w_next == DONE);
      r_pipe_start <= (r_state == CALC2) && (w_next == RUN);
      r_pipe_abort <= w_abort && (r_state != IDLE);
      if (r_state == CALC1) begin
        r_wh <= w_wh;
      end
      if (r_state == CALC2) begin
        r_total <= w_total;
      end
      if (w_next == IDLE) begin
        r_count <= 32'd0;
      end else if ((r_state == RUN) && bus.out_word_valid) begin
        r_count <= r_count + 32'd1;
      end
    end
  end

  // Config writes land only while idle; a write arriving mid-job is dropped and flagged.
  always_ff @(posedge bus_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cfg_width     <= 12'd0;
      r_cfg_height    <= 12'd0;
      r_cfg_n_kernels <= 8'd0;
      r_cfg_shift     <= 5'd0;
      r_cfg_err       <= 1'b0;
    end else begin
      if (bus.user_w_config_wren) begin
        if (r_state == IDLE) begin
          case (bus.user_config_addr)
            5'd0:    r_cfg_width     <= bus.user_w_config_data[11:0];
            5'd1:    r_cfg_height    <= bus.user_w_config_data[11:0];
            5'd2:    r_cfg_n_kernels <= bus.user_w_config_data[7:0];
            5'd3:    r_cfg_shift     <= bus.user_w_config_data[4:0];
            default: r_cfg_width     <= r_cfg_width;
          endcase
        end else begin
          r_cfg_err <= 1'b1;
        end
      end
      if ((r_state == IDLE) && w_start) begin
        r_cfg_err <= 1'b0;
      end
    end
  end

  assign bus.user_w_config_full  = 1'b0;
  assign bus.user_w_command_full = 1'b0;
  assign bus.user_r_read_32_eof  = r_eof;
  assign bus.cfg_width           = r_cfg_width;
  assign bus.cfg_height          = r_cfg_height;
  assign bus.cfg_n_kernels       = r_cfg_n_kernels;
  assign bus.cfg_shift           = r_cfg_shift;
  assign bus.pipe_start          = r_pipe_start;
  assign bus.pipe_abort          = r_pipe_abort;
  assign bus.busy                = r_busy;
  assign bus.cfg_err             = r_cfg_err;

  assign w_unused = &{1'b0, bus.user_w_config_open, bus.user_config_addr_update,
                      bus.user_w_command_open, bus.user_w_config_data[31:12]};
endmodule

// File: tb/tb_conv_ctrl.sv
// Directed self-checking bench for conv_ctrl with hand-computed expectations.
module tb_conv_ctrl;
  logic bus_clk = 1'b0;
  logic bus_rst_n;
  int   n_checks = 0;
  int   n_fail = 0;
  int   eof_seen = 0;
  int   abort_seen = 0;
  int   e0;
  int   a0;
  logic [31:0] exp_wh;
  logic [31:0] exp_total;

  localparam logic [7:0] START = 8'h01;
  localparam logic [7:0] ABORT = 8'h02;

  conv_ctrl_if bus();

  conv_ctrl dut (
    .bus_clk   (bus_clk),
    .bus_rst_n (bus_rst_n),
    .bus       (bus)
  );

  always #5 bus_clk = ~bus_clk;

  // Running tallies of eof and pipe_abort cycles.
  always @(posedge bus_clk) begin
    if (bus.user_r_read_32_eof) eof_seen <= eof_seen + 1;
    if (bus.pipe_abort) abort_seen <= abort_seen + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge bus_clk);
    #1;
  endtask

  task automatic cfg_write(input logic [4:0] addr, input logic [31:0] data);
    bus.user_config_addr   = addr;
    bus.user_w_config_data = data;
    bus.user_w_config_wren = 1'b1;
    tick();
    bus.user_w_config_wren = 1'b0;
  endtask

  task automatic cmd(input logic [7:0] b);
    bus.user_w_command_data = b;
    bus.user_w_command_wren = 1'b1;
    tick();
    bus.user_w_command_wren = 1'b0;
  endtask

  task automatic check_all_reset(input string tag);
    check({tag, "_width"},  32'(bus.cfg_width), 32'd0);
    check({tag, "_height"}, 32'(bus.cfg_height), 32'd0);
    check({tag, "_nk"},     32'(bus.cfg_n_kernels), 32'd0);
    check({tag, "_shift"},  32'(bus.cfg_shift), 32'd0);
    check({tag, "_start"},  32'(bus.pipe_start), 32'd0);
    check({tag, "_abort"},  32'(bus.pipe_abort), 32'd0);
    check({tag, "_eof"},    32'(bus.user_r_read_32_eof), 32'd0);
    check({tag, "_busy"},   32'(bus.busy), 32'd0);
    check({tag, "_err"},    32'(bus.cfg_err), 32'd0);
    check({tag, "_count"},  dut.r_count, 32'd0);
    check({tag, "_total"},  dut.r_total, 32'd0);
  endtask

  initial begin
    bus.user_w_config_wren      = 1'b0;
    bus.user_w_config_data      = 32'd0;
    bus.user_w_config_open      = 1'b1;
    bus.user_config_addr        = 5'd0;
    bus.user_config_addr_update = 1'b0;
    bus.user_w_command_wren     = 1'b0;
    bus.user_w_command_data     = 8'd0;
    bus.user_w_command_open     = 1'b1;
    bus.out_word_valid          = 1'b0;
    bus.user_r_read_32_open     = 1'b0;
    bus_rst_n                   = 1'b0;
    tick();
    tick();
    check_all_reset("rst");
    check("rst_full_cfg", 32'(bus.user_w_config_full), 32'd0);
    check("rst_full_cmd", 32'(bus.user_w_command_full), 32'd0);
    bus_rst_n = 1'b1;
    tick();
    tick();
    tick();

    // Basic job: 4x3x2 = 24 words
    cfg_write(5'd0, 32'd4);
    check("cfg_width", 32'(bus.cfg_width), 32'd4);
    cfg_write(5'd1, 32'd3);
    check("cfg_height", 32'(bus.cfg_height), 32'd3);
    cfg_write(5'd2, 32'd2);
    check("cfg_nk", 32'(bus.cfg_n_kernels), 32'd2);
    cfg_write(5'd3, 32'd7);
    check("cfg_shift", 32'(bus.cfg_shift), 32'd7);
    cfg_write(5'd9, 32'h0000_0ABC);
    check("cfg_hi_addr_width", 32'(bus.cfg_width), 32'd4);
    check("cfg_hi_addr_err", 32'(bus.cfg_err), 32'd0);
    bus.user_r_read_32_open = 1'b1;
    cmd(START);
    check("j1_busy_calc1", 32'(bus.busy), 32'd1);
    check("j1_start_c1", 32'(bus.pipe_start), 32'd0);
    tick();
    check("j1_start_c2", 32'(bus.pipe_start), 32'd0);
    check("j1_wh", 32'(dut.r_wh), 32'd12);
    tick();
    check("j1_start_c3", 32'(bus.pipe_start), 32'd1);
    check("j1_total", dut.r_total, 32'd24);
    for (int i = 1; i <= 24; i++) begin
      bus.out_word_valid = 1'b1;
      tick();
      if (i == 1) check("j1_start_drop", 32'(bus.pipe_start), 32'd0);
      if (i == 10) check("j1_count10", dut.r_count, 32'd10);
      if (i == 23) check("j1_eof_early", 32'(bus.user_r_read_32_eof), 32'd0);
    end
    bus.out_word_valid = 1'b0;
    check("j1_eof", 32'(bus.user_r_read_32_eof), 32'd1);
    check("j1_count24", dut.r_count, 32'd24);
    bus.out_word_valid = 1'b1;
    tick();
    tick();
    bus.out_word_valid = 1'b0;
    check("j1_count_cap", dut.r_count, 32'd24);
    check("j1_eof_hold", 32'(bus.user_r_read_32_eof), 32'd1);
    check("j1_busy_done", 32'(bus.busy), 32'd1);
    bus.user_r_read_32_open = 1'b0;
    tick();
    check("j1_eof_clr", 32'(bus.user_r_read_32_eof), 32'd0);
    check("j1_busy_idle", 32'(bus.busy), 32'd0);
    check("j1_count_clr", dut.r_count, 32'd0);

    // Zero kernels: straight to DONE
    cfg_write(5'd2, 32'd0);
    cmd(START);
    check("z_start_c1", 32'(bus.pipe_start), 32'd0);
    tick();
    check("z_eof_c2", 32'(bus.user_r_read_32_eof), 32'd0);
    tick();
    check("z_eof_c3", 32'(bus.user_r_read_32_eof), 32'd1);
    check("z_start_c3", 32'(bus.pipe_start), 32'd0);
    tick();
    check("z_busy_idle", 32'(bus.busy), 32'd0);

    // Dropped config write, ignored START, abort after 10 words
    cfg_write(5'd2, 32'd2);
    bus.user_r_read_32_open = 1'b1;
    e0 = eof_seen;
    cmd(START);
    tick();
    tick();
    check("ab_start", 32'(bus.pipe_start), 32'd1);
    for (int i = 0; i < 10; i++) begin
      bus.out_word_valid = 1'b1;
      tick();
    end
    bus.out_word_valid = 1'b0;
    check("ab_count10", dut.r_count, 32'd10);
    cmd(START);
    check("ab_restart_start", 32'(bus.pipe_start), 32'd0);
    check("ab_restart_count", dut.r_count, 32'd10);
    cfg_write(5'd0, 32'd99);
    check("ab_drop_width", 32'(bus.cfg_width), 32'd4);
    check("ab_drop_err", 32'(bus.cfg_err), 32'd1);
    cmd(ABORT);
    check("ab_pulse", 32'(bus.pipe_abort), 32'd1);
    check("ab_busy", 32'(bus.busy), 32'd0);
    check("ab_eof", 32'(bus.user_r_read_32_eof), 32'd0);
    check("ab_count", dut.r_count, 32'd0);
    tick();
    check("ab_pulse_end", 32'(bus.pipe_abort), 32'd0);
    check("ab_eof_never", 32'(eof_seen), 32'(e0));
    check("ab_err_sticky", 32'(bus.cfg_err), 32'd1);
    cmd(ABORT);
    check("idle_abort_pulse", 32'(bus.pipe_abort), 32'd0);
    check("idle_abort_busy", 32'(bus.busy), 32'd0);
    cmd(8'h55);
    check("bad_cmd_busy", 32'(bus.busy), 32'd0);
    cmd(START);
    check("err_clr", 32'(bus.cfg_err), 32'd0);
    check("err_clr_busy", 32'(bus.busy), 32'd1);
    cmd(ABORT);
    check("calc_abort", 32'(bus.pipe_abort), 32'd1);
    check("calc_abort_busy", 32'(bus.busy), 32'd0);

    // Config and START in the same cycle: CALC1 sees the new width
    bus.user_config_addr    = 5'd0;
    bus.user_w_config_data  = 32'd5;
    bus.user_w_config_wren  = 1'b1;
    bus.user_w_command_data = START;
    bus.user_w_command_wren = 1'b1;
    tick();
    bus.user_w_config_wren  = 1'b0;
    bus.user_w_command_wren = 1'b0;
    check("same_width", 32'(bus.cfg_width), 32'd5);
    tick();
    check("same_wh", 32'(dut.r_wh), 32'd15);
    cmd(ABORT);
    check("same_abort", 32'(bus.busy), 32'd0);

    // Last word and ABORT together: abort wins (total 2*1*1 = 2)
    cfg_write(5'd0, 32'd2);
    cfg_write(5'd1, 32'd1);
    cfg_write(5'd2, 32'd1);
    e0 = eof_seen;
    cmd(START);
    tick();
    tick();
    bus.out_word_valid = 1'b1;
    tick();
    bus.user_w_command_data = ABORT;
    bus.user_w_command_wren = 1'b1;
    tick();
    bus.user_w_command_wren = 1'b0;
    bus.out_word_valid      = 1'b0;
    check("race_busy", 32'(bus.busy), 32'd0);
    check("race_eof", 32'(bus.user_r_read_32_eof), 32'd0);
    check("race_abort", 32'(bus.pipe_abort), 32'd1);
    tick();
    check("race_eof_never", 32'(eof_seen), 32'(e0));

    // Maximum operands: 4095*4095*255 computed exactly in 32 bits
    cfg_write(5'd0, 32'hFFFF_FFFF);
    cfg_write(5'd1, 32'h0000_0FFF);
    cfg_write(5'd2, 32'hFFFF_FFFF);
    cfg_write(5'd3, 32'hFFFF_FFFF);
    check("max_width", 32'(bus.cfg_width), 32'd4095);
    check("max_height", 32'(bus.cfg_height), 32'd4095);
    check("max_nk", 32'(bus.cfg_n_kernels), 32'd255);
    check("max_shift", 32'(bus.cfg_shift), 32'd31);
    exp_wh    = 32'd4095 * 32'd4095;
    exp_total = exp_wh * 32'd255;
    cmd(START);
    tick();
    check("max_wh", 32'(dut.r_wh), exp_wh);
    tick();
    check("max_total", dut.r_total, exp_total);
    check("max_start", 32'(bus.pipe_start), 32'd1);
    bus.out_word_valid = 1'b1;
    tick();
    tick();
    tick();
    bus.out_word_valid = 1'b0;
    cfg_write(5'd1, 32'd7);
    check("stable_height", 32'(bus.cfg_height), 32'd4095);
    check("stable_err", 32'(bus.cfg_err), 32'd1);

    // Reset mid-RUN: immediate clear, no abort pulse
    a0 = abort_seen;
    bus_rst_n = 1'b0;
    #1;
    check_all_reset("midrst");
    tick();
    tick();
    bus_rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("midrst_no_abort", 32'(abort_seen), 32'(a0));
    check("midrst_busy", 32'(bus.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
